// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
//   op_e    : operation encoding presented on the op port (0..7)
//   state_e : control FSM states
package muldiv_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        ADJUST = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_ctrl.sv
// Control FSM and iteration counter for muldiv_seq.
// Ports:
//   Clk, Reset_n          : clock, async active-low reset
//   req_valid, kill       : request strobe, abort of the operation in flight
//   resp_ready            : consumer accepts the response
//   early                 : latched operands need no iteration (shortcut to DONE)
//   state                 : current FSM state (registered)
//   req_ready, busy,
//   resp_valid            : registered handshake / status outputs
//   accept_c              : request accepted on this edge (combinational)
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic   Clk,
    input  logic   Reset_n,
    input  logic   req_valid,
    input  logic   kill,
    input  logic   resp_ready,
    input  logic   early,
    output state_e state,
    output logic   req_ready,
    output logic   busy,
    output logic   resp_valid,
    output logic   accept_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;

    assign accept_c = req_valid & req_ready;

    // Next state and counter
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_next = CALC;
                    cnt_next   = CNT_W'(WIDTH);
                end
            end
            CALC: begin
                if (kill) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (early) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                    // Leaving at count 1 yields exactly WIDTH iteration cycles
                    if (cnt == CNT_W'(1)) begin
                        state_next = ADJUST;
                    end
                end
            end
            ADJUST: begin
                state_next = kill ? IDLE : DONE;
            end
            DONE: begin
                // kill takes the same exit as a handshake; consumer drops the result
                if (kill || resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State register; status outputs are registered from the next state
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            req_ready  <= (state_next == IDLE);
            busy       <= (state_next != IDLE);
            resp_valid <= (state_next == DONE);
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply/divide unit (RISC-V M-extension style ops).
// One operand bit per cycle on magnitudes, followed by a one-cycle sign
// correction / result select.
// Ports:
//   Clk, Reset_n            : clock, async active-low reset
//   req_valid/req_ready     : request handshake; op, a, b sampled on accept
//   kill                    : abort the operation in flight
//   resp_valid/resp_ready   : response handshake; result held while stalled
//   busy                    : unit is not idle
// Build option: MULDIV_EARLY_OUT_EN -- divide-by-zero, signed overflow and
// multiply by zero skip the iterations and respond one cycle after accept.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned     W2      = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e             state;
    logic               accept_c;
    logic               early_c;

    op_e                op_in_c;
    logic               neg_a_c;
    logic               neg_b_c;
    logic [WIDTH-1:0]   mag_a_c;
    logic [WIDTH-1:0]   mag_b_c;
    logic               special_c;
    logic [WIDTH-1:0]   special_res_c;

    op_e                op_q;
    logic               neg_a_q;
    logic               neg_b_q;
    logic               special_q;
    logic [WIDTH-1:0]   special_res_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [W2-1:0]      acc;

    logic               is_div_c;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH:0]     shifted_c;
    logic [WIDTH:0]     diff_c;
    logic [W2-1:0]      acc_step_c;
    logic [W2-1:0]      prod_c;
    logic [WIDTH-1:0]   quo_c;
    logic [WIDTH-1:0]   rem_c;
    logic [WIDTH-1:0]   res_next_c;
    logic               res_load_c;

    muldiv_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .req_valid  (req_valid),
        .kill       (kill),
        .resp_ready (resp_ready),
        .early      (early_c),
        .state      (state),
        .req_ready  (req_ready),
        .busy       (busy),
        .resp_valid (resp_valid),
        .accept_c   (accept_c)
    );

`ifdef MULDIV_EARLY_OUT_EN
    assign early_c = special_q;
`else
    assign early_c = 1'b0;
`endif

    // Operand signs, magnitudes and special-case detection at the request port
    always_comb begin
        op_in_c       = op_e'(op);
        neg_a_c       = 1'b0;
        neg_b_c       = 1'b0;
        special_c     = 1'b0;
        special_res_c = '0;
        if (op_in_c inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) begin
            neg_a_c = a[WIDTH-1];
        end
        if (op_in_c inside {OP_MULH, OP_DIV, OP_REM}) begin
            neg_b_c = b[WIDTH-1];
        end
        mag_a_c = neg_a_c ? -a : a;
        mag_b_c = neg_b_c ? -b : b;
        if (op[2]) begin
            // op[1] selects remainder, op[0] selects unsigned
            if (b == '0) begin
                special_c     = 1'b1;
                special_res_c = op[1] ? a : '1;
            end else if (!op[0] && a == MIN_NEG && b == '1) begin
                special_c     = 1'b1;
                special_res_c = op[1] ? '0 : a;
            end
        end else if (a == '0 || b == '0) begin
            special_c     = 1'b1;
            special_res_c = '0;
        end
    end

    // One radix-2 step: shift-add multiply or restoring divide
    always_comb begin
        is_div_c  = (op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
        sum_c     = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? opnd_q : {WIDTH{1'b0}})};
        shifted_c = {acc[W2-1:WIDTH], acc[WIDTH-1]};
        diff_c    = shifted_c - {1'b0, opnd_q};
        if (!is_div_c) begin
            acc_step_c = {sum_c, acc[WIDTH-1:1]};
        end else if (diff_c[WIDTH]) begin
            acc_step_c = {shifted_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_step_c = {diff_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction and result half select; special cases bypass correction
    always_comb begin
        prod_c     = (neg_a_q ^ neg_b_q) ? -acc : acc;
        quo_c      = (neg_a_q ^ neg_b_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_c      = neg_a_q ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
        res_next_c = '0;
        case (op_q)
            OP_MUL:                       res_next_c = acc[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_next_c = prod_c[W2-1:WIDTH];
            OP_DIV, OP_DIVU:              res_next_c = quo_c;
            OP_REM, OP_REMU:              res_next_c = rem_c;
            default:                      res_next_c = '0;
        endcase
        if (special_q) begin
            res_next_c = special_res_q;
        end
        res_load_c = (state == ADJUST) || (state == CALC && early_c);
    end

    // Datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            op_q          <= OP_MUL;
            neg_a_q       <= 1'b0;
            neg_b_q       <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            opnd_q        <= '0;
            acc           <= '0;
            result        <= '0;
        end else begin
            if (accept_c) begin
                op_q          <= op_in_c;
                neg_a_q       <= neg_a_c;
                neg_b_q       <= neg_b_c;
                special_q     <= special_c;
                special_res_q <= special_res_c;
                // Multiply: opnd = multiplicand, acc.lo = multiplier.
                // Divide:   opnd = divisor,      acc.lo = dividend.
                opnd_q        <= op[2] ? mag_b_c : mag_a_c;
                acc           <= {{WIDTH{1'b0}}, (op[2] ? mag_a_c : mag_b_c)};
            end else if (state == CALC) begin
                acc <= acc_step_c;
            end
            if (res_load_c) begin
                result <= res_next_c;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vectors feed an expected-value
// queue; monitors compare result and latency when a response appears.
module tb_muldiv_seq;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    typedef struct {
        logic [31:0] want;
        int          lat;
        string       name;
    } exp_t;

    logic        Clk;
    logic        Reset_n;
    logic        req_valid, req_ready, kill, resp_valid, resp_ready, busy;
    logic [2:0]  op;
    logic [31:0] a, b, result;

    logic        req_valid8, req_ready8, kill8, resp_valid8, resp_ready8, busy8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, result8;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   acc_cyc8 = 0;
    bit   prev_valid = 1'b0;
    bit   prev_valid8 = 1'b0;
    exp_t sb[$];
    exp_t sb8[$];

    muldiv_seq #(.WIDTH(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .op(op), .a(a), .b(b), .kill(kill), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .result(result), .busy(busy)
    );

    muldiv_seq #(.WIDTH(8)) dut8 (
        .Clk(Clk), .Reset_n(Reset_n), .req_valid(req_valid8), .req_ready(req_ready8),
        .op(op8), .a(a8), .b(b8), .kill(kill8), .resp_valid(resp_valid8),
        .resp_ready(resp_ready8), .result(result8), .busy(busy8)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    function automatic int lat32(input bit special);
        return (EO && special) ? 1 : 33;
    endfunction

    // Monitor for the 32-bit unit: compare on the first cycle of each response
    always @(negedge Clk) begin : mon32
        exp_t e;
        if (Reset_n && resp_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: result %h with nothing outstanding", result);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, 64'(result), 64'(e.want));
                check({e.name, "_latency"}, 64'(cyc - acc_cyc), 64'(e.lat));
            end
        end
        prev_valid = resp_valid;
    end

    // Monitor for the 8-bit unit
    always @(negedge Clk) begin : mon8
        exp_t e;
        if (Reset_n && resp_valid8 && !prev_valid8) begin
            if (sb8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp8: result %h with nothing outstanding", result8);
            end else begin
                e = sb8.pop_front();
                check({e.name, "_result"}, 64'(result8), 64'(e.want));
                check({e.name, "_latency"}, 64'(cyc - acc_cyc8), 64'(e.lat));
            end
        end
        prev_valid8 = resp_valid8;
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] want, input int lat, input string name, input bit push);
        int n = 0;
        @(negedge Clk);
        while (!req_ready && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL %s_accept: req_ready low for %0d cycles", name, n);
        end
        op        = o;
        a         = x;
        b         = y;
        req_valid = 1'b1;
        if (push) sb.push_back('{want, lat, name});
        @(posedge Clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge Clk);
        while (busy && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy still high after %0d cycles", name, n);
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] want, input bit special, input string name);
        issue(o, x, y, want, lat32(special), name, 1'b1);
        wait_idle(name);
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] want, input string name);
        int n = 0;
        @(negedge Clk);
        op8        = o;
        a8         = x;
        b8         = y;
        req_valid8 = 1'b1;
        sb8.push_back('{32'(want), 9, name});
        @(posedge Clk);
        #1;
        acc_cyc8   = cyc;
        req_valid8 = 1'b0;
        @(negedge Clk);
        while (busy8 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (busy8) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: busy8 still high", name);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int  n;
        bit  seen;
        Reset_n     = 1'b1;
        req_valid   = 1'b0; kill  = 1'b0; resp_ready  = 1'b1;
        op = '0; a = '0; b = '0;
        req_valid8  = 1'b0; kill8 = 1'b0; resp_ready8 = 1'b1;
        op8 = '0; a8 = '0; b8 = '0;
        #1 Reset_n = 1'b0;
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_req_ready8", 64'(req_ready8), 64'd1);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Directed vectors: op, a, b, expected, takes early-out path
        run(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_m3");
        run(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu_max");
        run(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0, "mulhsu_m1_2");
        run(OP_MULH,   32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 1'b0, "mulh_m2_3");
        run(OP_MULH,   32'h4000_0000,  32'd4,         32'h0000_0001, 1'b0, "mulh_2p30_4");
        run(OP_MUL,    32'd0,          32'd12345,     32'd0,         1'b1, "mul_zero");
        run(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, "div_m7_2");
        run(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, "rem_m7_2");
        run(OP_DIVU,   32'd100,        32'd7,         32'd14,        1'b0, "divu_100_7");
        run(OP_REMU,   32'd100,        32'd7,         32'd2,         1'b0, "remu_100_7");
        run(OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, "divu_by0");
        run(OP_REM,    32'd5,          32'd0,         32'd5,         1'b1, "rem_by0");
        run(OP_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1'b1, "div_m7_by0");
        run(OP_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1'b1, "rem_m7_by0");
        run(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
        run(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1, "rem_ovf");

        // Consumer stall: response held for 5 cycles
        resp_ready = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "stall", 1'b1);
        n = 0;
        @(negedge Clk);
        while (!resp_valid && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check("stall_resp_seen", 64'(resp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge Clk);
            check("stall_result", 64'(result), 64'd14);
            check("stall_req_ready", 64'(req_ready), 64'd0);
            check("stall_resp_valid", 64'(resp_valid), 64'd1);
        end
        resp_ready = 1'b1;
        @(posedge Clk);
        #1;
        check("stall_release_busy", 64'(busy), 64'd0);
        check("stall_release_req_ready", 64'(req_ready), 64'd1);
        check("stall_release_resp_valid", 64'(resp_valid), 64'd0);

        // Kill during the tenth iteration cycle
        issue(OP_MUL, 32'd3, 32'd5, 32'd0, 0, "kill", 1'b0);
        repeat (9) @(posedge Clk);
        @(negedge Clk);
        kill = 1'b1;
        @(posedge Clk);
        #1;
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'd0);
        check("kill_req_ready", 64'(req_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (resp_valid) seen = 1'b1;
        end
        check("kill_no_resp", 64'(seen), 64'd0);

        // Asynchronous reset mid-iteration
        issue(OP_MUL, 32'd3, 32'd5, 32'd0, 0, "reset", 1'b0);
        repeat (5) @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (resp_valid) seen = 1'b1;
        end
        check("midrst_no_resp", 64'(seen), 64'd0);
        run(OP_MUL, 32'h0001_2345, 32'h10, 32'h0012_3450, 1'b0, "mul_after_rst");

        // Narrow configuration
        run8(OP_DIVU, 8'd200, 8'd7, 8'd28, "w8_divu_200_7");
        run8(OP_REMU, 8'd200, 8'd7, 8'd4,  "w8_remu_200_7");

        repeat (3) @(negedge Clk);
        check("sb_drained", 64'(sb.size() + sb8.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and result width in bits (legal values 8..64, even).
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port op, input, 3 bits: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU, encoded 0..7.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: a is the multiplicand or dividend; b is the multiplier or divisor.
REQ-008 The block SHALL have port kill, input, 1 bit: abort the operation in flight.
REQ-009 The block SHALL have port resp_valid, output, 1 bit: result is valid.
REQ-010 The block SHALL have port resp_ready, input, 1 bit: consumer accepts result; low means stall.
REQ-011 The block SHALL have port result, output, WIDTH bits: the operation result.
REQ-012 The block SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, ADJUST and DONE.
- IDLE: req_ready = 1.
- A request is accepted on an edge where req_valid & req_ready.
REQ-014 On acceptance the block SHALL latch op, a and b, and load the iteration counter with WIDTH; on that edge the state goes to CALC.
REQ-015 In CALC the block SHALL process one radix-2 step per cycle on operand magnitudes:
- multiply: shift-add into a 2*WIDTH accumulator;
- divide: restoring shift-subtract.
- Counter decrements each cycle; leaving at counter 1 gives exactly WIDTH CALC cycles, then ADJUST.
REQ-016 ADJUST SHALL take one cycle to apply sign correction, select the result half and register result; the next state is DONE.
REQ-017 Latency SHALL be: resp_valid high in cycle WIDTH+1 after the accept edge (accept edge = cycle 0).
REQ-018 Sign rules SHALL be:
- MULH: both operands signed.
- MULHSU: a signed, b unsigned.
- MULHU, DIVU and REMU: unsigned.
- Quotient negated when operand signs differ.
- Remainder takes the dividend's sign.
REQ-019 MUL SHALL return the low WIDTH bits of the product; the MULH variants SHALL return the high WIDTH bits.
REQ-020 Division by zero SHALL return quotient all-ones (DIV and DIVU) and remainder = a (REM and REMU), with no sign correction.
REQ-021 Signed overflow (a = -2^(WIDTH-1), b = -1) SHALL return DIV = a and REM = 0.
REQ-022 In DONE the block SHALL hold resp_valid = 1 with result stable until resp_ready = 1, then return to IDLE on that edge; req_ready = 0 in DONE, so there is no back-to-back overlap.
REQ-023 kill asserted in CALC, ADJUST or DONE SHALL force IDLE on the next edge with no resp_valid; kill in IDLE SHALL be ignored.
REQ-024 If kill and a response handshake occur on the same edge, kill SHALL win, and the consumer SHALL discard that result.
REQ-025 busy SHALL be 0 only in IDLE.

Reset
REQ-026 When Reset_n = 0 the block SHALL asynchronously force:
- state IDLE and counter 0;
- result 0, resp_valid 0, busy 0 and req_ready 1, the last taking effect immediately.
REQ-027 Reset asserted mid-operation SHALL discard all operation state, with no response produced.

Configuration
REQ-028 When macro MULDIV_EARLY_OUT_EN is defined, the following cases SHALL skip CALC and ADJUST and present resp_valid in cycle 1 after acceptance:
- division by zero;
- signed overflow;
- multiply with a = 0 or b = 0 (result 0).
REQ-029 When MULDIV_EARLY_OUT_EN is undefined, every operation SHALL take the full REQ-017 latency.
REQ-030 Results SHALL be identical in both configurations.

Structure
REQ-031 Package muldiv_pkg SHALL hold the op enum, the state enum and the WIDTH default constant.
REQ-032 The FSM and counter (width $clog2(WIDTH+1)) SHALL live in sub-module muldiv_ctrl.
REQ-033 The accumulator, sign logic and result mux SHALL live in muldiv_seq.

Verification
REQ-034 The bench SHALL cover these directed scenarios (WIDTH = 32 unless stated):
- MUL a=7, b=-3: result 0xFFFFFFEB, resp_valid in cycle 33.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF: result 0xFFFFFFFE; MULHSU a=-1, b=2: result 0xFFFFFFFF.
- DIV a=-7, b=2: result -3; REM a=-7, b=2: result -1; DIVU a=5, b=0: result 0xFFFFFFFF; REM a=5, b=0: result 5.
- DIV a=0x80000000, b=-1: result 0x80000000; REM same operands: 0. With MULDIV_EARLY_OUT_EN, resp_valid in cycle 1.
- resp_ready held low 5 cycles in DONE: result stable, req_ready 0; back in IDLE the edge after resp_ready rises.
- kill at CALC cycle 10: no resp_valid, IDLE next edge. Reset_n pulsed mid-CALC: outputs at reset values immediately. WIDTH=8 DIVU 200/7: result 28 in cycle 9.
